sccb_cam_config: RTL and testbench
==================================

# sccb_cam_config

Camera register configuration sequencer for the video processing path. After a start request it walks an external register table (synchronous ROM of {reg_addr, value} words) and issues one SCCB 3-phase write per entry on SCL/SDA, driving the camera's SCCB pins that the video top exposes. It reports BUSY while configuring and DONE once the table is exhausted, so capture logic can hold off until the sensor is programmed.

## Interface
- CLK_DIV, 250: CLK cycles per SCCB quarter-bit (100 kHz SCL at 100 MHz CLK); legal ≥ 2
- DEV_ADDR, 8'h42: SCCB write device address, sent as phase 1
- NUM_REGS, 256: maximum table entries processed; ROM_ADDR width = clog2(NUM_REGS)
- PWR_WAIT, 100000: CLK cycles idle after START before the first write
- GAP_Q, 8: quarters of idle bus (SCL=1, SDA=1) between writes
- CLK  in  1  single clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- START  in  1  single-cycle pulse; begins a configuration run when idle or done
- ROM_ADDR  out  clog2(NUM_REGS)  table index to the synchronous ROM
- ROM_DATA  in  16  {reg_addr[15:8], value[7:0]}, valid 1 cycle after ROM_ADDR changes; 16'hFFFF = end of table
- SCL  out  1  SCCB clock, idles high
- SDA  out  1  SCCB data (write-only, push-pull), idles high
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  high after the run completes; cleared by the next accepted START

## Operation
- States: IDLE, PWR, FETCH, START_C, BITS, STOP_C, GAP, FIN.
- IDLE/FIN: SCL=1, SDA=1. START accepted in IDLE or FIN: ROM_ADDR←0, DONE←0, BUSY←1, go PWR. START in any other state ignored.
- PWR: count PWR_WAIT cycles, then FETCH.
- FETCH: 2 cycles (address settle + ROM latency), then latch ROM_DATA. If latched word = 16'hFFFF go FIN; else load 27-bit shift register {DEV_ADDR,1, reg_addr,1, value,1} (MSB first; the ninth bit of each phase is the don't-care bit, driven 1) and go START_C.
- Quarter tick: counter 0..CLK_DIV-1, tick on CLK_DIV-1; counter reset on every state entry. START_C/BITS/STOP_C/GAP advance only on ticks.
- START_C, 4 quarters: (SCL,SDA) = (1,1),(1,0),(0,0),(0,0).
- BITS, 27 bits × 4 quarters: q0,q1 SCL=0; q2,q3 SCL=1; SDA = current bit from start of q0, stable across SCL high; shift at end of q3.
- STOP_C, 4 quarters: (0,0),(1,0),(1,1),(1,1).
- GAP: GAP_Q quarters at (1,1). Then ROM_ADDR+1; if new index = NUM_REGS (i.e. the increment wraps to 0) go FIN, else FETCH.
- FIN: BUSY←0, DONE←1; hold until next START or reset.

## Timing
- Reset (RST_N low at a CLK edge): next cycle SCL=1, SDA=1, BUSY=0, DONE=0, ROM_ADDR=0, state IDLE, all counters 0; reset mid-transaction aborts immediately (stop condition not generated), in any state.
- START→BUSY: 1 cycle. PWR lasts exactly PWR_WAIT cycles.
- One write = (4 + 108 + 4 + GAP_Q) × CLK_DIV cycles + 2 FETCH cycles.
- SDA changes only while SCL=0, except the start (SDA falls with SCL high) and stop (SDA rises with SCL high) edges.
- SCL/SDA are registered outputs, glitch-free.
- End-of-table and NUM_REGS limit: the 16'hFFFF word produces no bus activity; FIN entered on the cycle after its FETCH latch. ROM_ADDR holds the terminating index.
- START coinciding with RST_N low: reset wins.

## Test plan
- CLK_DIV=4, PWR_WAIT=10, GAP_Q=2, ROM {0x1280, 0x1101, 0xFFFF}, pulse START -> BUSY rises next cycle; bus monitor decodes writes 42/12/80 then 42/11/01, each with start/stop and 1 don't-care bits; DONE=1, BUSY=0, ROM_ADDR=2; exactly 2×(118×4+2)+10+2 cycles (±1) from START to DONE.
- Same config, check every SCL high quarter: SDA stable; count 27 rising SCL edges per write; SCL low width 8 cycles, high width 8 cycles.
- ROM never 0xFFFF, NUM_REGS=4 -> exactly 4 writes, then DONE=1, ROM_ADDR back at 0.
- RST_N low mid-BITS of the first write -> next cycle SCL=1, SDA=1, BUSY=0; no further bus activity until new START; new run restarts from ROM_ADDR=0.
- START pulsed during BITS -> ignored; sequence and timing identical to undisturbed run. START after DONE -> DONE clears, full table replayed.
- ROM {0xFFFF} first entry -> zero SCL edges, DONE=1 after PWR_WAIT+3 cycles.

Source files
------------

// File: rtl/sccb_cam_config.sv
`default_nettype none
//============================================================================
// Module   : sccb_cam_config
// Purpose  : Camera register configuration sequencer. After START it waits
//            a power-up delay, then walks a synchronous register ROM of
//            {reg_addr, value} words. Each entry becomes one SCCB 3-phase
//            write (device address, register address, value). The run ends
//            on a 16'hFFFF entry or after NUM_REGS entries.
// Ports    : CLK      - single clock, rising edge
//            RST_N    - synchronous active-low reset
//            START    - single-cycle run request (honoured in IDLE/FIN)
//            ROM_ADDR - table index to the external synchronous ROM
//            ROM_DATA - {reg_addr, value}, valid one cycle after ROM_ADDR
//            SCL/SDA  - registered SCCB clock/data, idle high
//            BUSY     - configuration run in progress
//            DONE     - run complete, held until next START
// Revision : 1.0 - initial release
//============================================================================
module sccb_cam_config #(
    parameter int         CLK_DIV  = 250,     // CLK cycles per quarter-bit, >= 2
    parameter logic [7:0] DEV_ADDR = 8'h42,
    parameter int         NUM_REGS = 256,     // >= 2
    parameter int         PWR_WAIT = 100000,  // >= 1
    parameter int         GAP_Q    = 8        // >= 1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        START,
    output logic [$clog2(NUM_REGS)-1:0] ROM_ADDR,
    input  logic [15:0]                 ROM_DATA,
    output logic                        SCL,
    output logic                        SDA,
    output logic                        BUSY,
    output logic                        DONE
);

    localparam int c_addrW = $clog2(NUM_REGS);
    localparam int c_divW  = $clog2(CLK_DIV);
    localparam int c_pwrW  = $clog2(PWR_WAIT + 1);
    localparam int c_cntW  = (c_divW > c_pwrW) ? c_divW : c_pwrW;
    localparam int c_qW    = (GAP_Q > 4) ? $clog2(GAP_Q) : 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PWR    = 3'd1,
        S_FETCH  = 3'd2,
        S_STARTC = 3'd3,
        S_BITS   = 3'd4,
        S_STOPC  = 3'd5,
        S_GAP    = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_cntW-1:0]   r_cnt;       // PWR/FETCH cycle count, or quarter divider
    logic [c_qW-1:0]     r_quarter;   // quarter index within the current phase
    logic [4:0]          r_bitCnt;    // bit index 0..26 while in BITS
    logic [26:0]         r_shift;
    logic [c_addrW-1:0]  r_romAddr;
    logic                r_scl;
    logic                r_sda;
    logic                w_sclNext;
    logic                w_sdaNext;
    logic                w_tick;
    logic                w_q3;
    logic                w_gapLast;
    logic                w_lastEntry;
    logic                w_quarterState;

    assign w_tick         = (r_cnt == c_cntW'(CLK_DIV - 1));
    assign w_q3           = (r_quarter == c_qW'(3));
    assign w_gapLast      = (r_quarter == c_qW'(GAP_Q - 1));
    assign w_lastEntry    = (r_romAddr == c_addrW'(NUM_REGS - 1));
    assign w_quarterState = (r_state == S_STARTC) || (r_state == S_BITS) ||
                            (r_state == S_STOPC)  || (r_state == S_GAP);

    // Next state and next bus levels. Bus levels are decoded from the
    // current state/quarter and registered, so the pins trail the state
    // register by one cycle uniformly and never glitch.
    always_comb begin
        w_stateNext = r_state;
        w_sclNext   = 1'b1;
        w_sdaNext   = 1'b1;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (START) w_stateNext = S_PWR;
            end
            S_PWR: begin
                if (r_cnt == c_cntW'(PWR_WAIT - 1)) w_stateNext = S_FETCH;
            end
            S_FETCH: begin
                // Second FETCH cycle: ROM output now reflects ROM_ADDR.
                if (r_cnt == c_cntW'(1))
                    w_stateNext = (ROM_DATA == 16'hFFFF) ? S_FIN : S_STARTC;
            end
            S_STARTC: begin
                // (1,1),(1,0),(0,0),(0,0): SDA falls while SCL high.
                w_sclNext = ~r_quarter[1];
                w_sdaNext = (r_quarter == '0);
                if (w_tick && w_q3) w_stateNext = S_BITS;
            end
            S_BITS: begin
                w_sclNext = r_quarter[1];
                w_sdaNext = r_shift[26];
                if (w_tick && w_q3 && (r_bitCnt == 5'd26)) w_stateNext = S_STOPC;
            end
            S_STOPC: begin
                // (0,0),(1,0),(1,1),(1,1): SDA rises while SCL high.
                w_sclNext = (r_quarter != '0);
                w_sdaNext = r_quarter[1];
                if (w_tick && w_q3) w_stateNext = S_GAP;
            end
            S_GAP: begin
                if (w_tick && w_gapLast) w_stateNext = w_lastEntry ? S_FIN : S_FETCH;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_stateNext;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt     <= '0;
            r_quarter <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_romAddr <= '0;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
        end else begin
            r_scl <= w_sclNext;
            r_sda <= w_sdaNext;

            // All counters restart on every state entry.
            if (w_stateNext != r_state) begin
                r_cnt     <= '0;
                r_quarter <= '0;
                r_bitCnt  <= '0;
            end else if (w_quarterState) begin
                if (w_tick) begin
                    r_cnt <= '0;
                    if ((r_state == S_BITS) && w_q3) begin
                        r_quarter <= '0;
                        r_bitCnt  <= r_bitCnt + 5'd1;
                        r_shift   <= {r_shift[25:0], 1'b1};
                    end else begin
                        r_quarter <= r_quarter + c_qW'(1);
                    end
                end else begin
                    r_cnt <= r_cnt + c_cntW'(1);
                end
            end else if ((r_state == S_PWR) || (r_state == S_FETCH)) begin
                r_cnt <= r_cnt + c_cntW'(1);
            end

            if (((r_state == S_IDLE) || (r_state == S_FIN)) && START)
                r_romAddr <= '0;

            // Each phase ends with its don't-care bit driven high.
            if ((r_state == S_FETCH) && (w_stateNext == S_STARTC))
                r_shift <= {DEV_ADDR, 1'b1, ROM_DATA[15:8], 1'b1, ROM_DATA[7:0], 1'b1};

            // Incrementing past the last index wraps to 0 and ends the run.
            if ((r_state == S_GAP) && (w_stateNext != S_GAP))
                r_romAddr <= w_lastEntry ? '0 : r_romAddr + c_addrW'(1);
        end
    end

    assign ROM_ADDR = r_romAddr;
    assign SCL      = r_scl;
    assign SDA      = r_sda;
    assign BUSY     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign DONE     = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_sccb_cam_config.sv
`default_nettype none
//============================================================================
// Module   : tb_sccb_cam_config
// Purpose  : Directed self-checking bench for sccb_cam_config with a small
//            synchronous ROM model and an SCCB bus monitor that decodes
//            frames, counts SCL rising edges and measures SCL widths.
// Revision : 1.0 - initial release
//============================================================================
module tb_sccb_cam_config;

    localparam int CLK_DIV  = 4;
    localparam int PWR_WAIT = 10;
    localparam int GAP_Q    = 2;
    localparam int NUM_REGS = 4;

    localparam logic [26:0] W_1280 = {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1};
    localparam logic [26:0] W_1101 = {8'h42, 1'b1, 8'h11, 1'b1, 8'h01, 1'b1};
    localparam logic [26:0] W_3344 = {8'h42, 1'b1, 8'h33, 1'b1, 8'h44, 1'b1};

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic [1:0] romAddr;
    logic [15:0] romData = 16'hFFFF;
    logic       scl, sda, busy, done;
    logic [15:0] rom [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    int nChecks = 0, nPass = 0, nFail = 0;

    sccb_cam_config #(
        .CLK_DIV (CLK_DIV),
        .DEV_ADDR(8'h42),
        .NUM_REGS(NUM_REGS),
        .PWR_WAIT(PWR_WAIT),
        .GAP_Q   (GAP_Q)
    ) dut (
        .CLK     (clk),
        .RST_N   (rstN),
        .START   (start),
        .ROM_ADDR(romAddr),
        .ROM_DATA(romData),
        .SCL     (scl),
        .SDA     (sda),
        .BUSY    (busy),
        .DONE    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) romData <= rom[romAddr];

    logic        pScl = 1'b1, pSda = 1'b1;
    bit          inFrame = 1'b0;
    int          rises = 0, lowLen = 0, highLen = 0;
    int          sclRises = 0, badStable = 0, badWidth = 0, widthChecks = 0;
    logic [27:0] bits = '0;
    logic [26:0] words[$];
    int          riseCnt[$];

    always @(negedge clk) begin
        if (!rstN) begin
            inFrame = 1'b0;
            pScl = 1'b1; pSda = 1'b1;
            lowLen = 0; highLen = 0;
        end else begin
            if (scl && !pScl) begin
                sclRises++;
                if (inFrame) begin
                    if (rises >= 1 && rises <= 26) begin
                        widthChecks++;
                        if (lowLen != 8) badWidth++;
                    end
                    bits = {bits[26:0], sda};
                    rises++;
                end
            end
            if (!scl && pScl && inFrame && rises >= 1) begin
                widthChecks++;
                if (highLen != 8) badWidth++;
            end
            if (scl && pScl && pSda && !sda) begin
                if (inFrame) badStable++;
                inFrame = 1'b1; rises = 0; bits = '0;
            end else if (scl && pScl && !pSda && sda && inFrame) begin
                words.push_back(bits[27:1]);
                riseCnt.push_back(rises);
                inFrame = 1'b0;
            end
            if (scl != pScl) begin lowLen = 0; highLen = 0; end
            if (scl) highLen++; else lowLen++;
            pScl = scl; pSda = sda;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, inout int n);
        while (!done && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic clearMon();
        words.delete();
        riseCnt.delete();
    endtask

    int n;
    int rise0;

    initial begin
        repeat (3) step();
        nChecks++; if (scl === 1'b1) nPass++; else begin nFail++; $error("FAIL reset_scl: %0h", scl); end
        nChecks++; if (sda === 1'b1) nPass++; else begin nFail++; $error("FAIL reset_sda: %0h", sda); end
        nChecks++; if (busy === 1'b0) nPass++; else begin nFail++; $error("FAIL reset_busy: %0h", busy); end
        nChecks++; if (done === 1'b0) nPass++; else begin nFail++; $error("FAIL reset_done: %0h", done); end
        nChecks++; if (romAddr === 2'd0) nPass++; else begin nFail++; $error("FAIL reset_romaddr: %0h", romAddr); end
        rstN = 1'b1;
        step();

        rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
        clearMon();
        pulseStart();
        nChecks++; if (busy === 1'b1) nPass++; else begin nFail++; $error("FAIL t1_busy_rise: %0h", busy); end
        n = 1;
        waitDone(3000, n);
        nChecks++; if (n >= 959 && n <= 961) nPass++; else begin nFail++; $error("FAIL t1_cycles: %0d", n); end
        nChecks++; if (done === 1'b1) nPass++; else begin nFail++; $error("FAIL t1_done: %0h", done); end
        nChecks++; if (busy === 1'b0) nPass++; else begin nFail++; $error("FAIL t1_busy: %0h", busy); end
        nChecks++; if (romAddr === 2'd2) nPass++; else begin nFail++; $error("FAIL t1_romaddr: %0h", romAddr); end
        nChecks++; if (words.size() == 2) nPass++; else begin nFail++; $error("FAIL t1_nwords: %0d", words.size()); end
        nChecks++; if (((words.size() > 0) ? words[0] : 27'h0) === W_1280) nPass++; else begin nFail++; $error("FAIL t1_word0"); end
        nChecks++; if (((words.size() > 1) ? words[1] : 27'h0) === W_1101) nPass++; else begin nFail++; $error("FAIL t1_word1"); end
        nChecks++; if (((riseCnt.size() > 0) ? riseCnt[0] - 1 : 0) == 27) nPass++; else begin nFail++; $error("FAIL t1_rises0"); end
        nChecks++; if (((riseCnt.size() > 1) ? riseCnt[1] - 1 : 0) == 27) nPass++; else begin nFail++; $error("FAIL t1_rises1"); end
        nChecks++; if (badStable == 0) nPass++; else begin nFail++; $error("FAIL t1_sda_stable: %0d", badStable); end
        nChecks++; if (badWidth == 0) nPass++; else begin nFail++; $error("FAIL t1_scl_width: %0d", badWidth); end
        nChecks++; if (widthChecks >= 100 && widthChecks <= 200) nPass++; else begin nFail++; $error("FAIL t1_width_checks: %0d", widthChecks); end

        clearMon();
        pulseStart();
        nChecks++; if (done === 1'b0) nPass++; else begin nFail++; $error("FAIL t2_done_clear: %0h", done); end
        nChecks++; if (busy === 1'b1) nPass++; else begin nFail++; $error("FAIL t2_busy: %0h", busy); end
        n = 1;
        repeat (199) begin step(); n++; end
        pulseStart();
        n++;
        waitDone(3000, n);
        nChecks++; if (n >= 959 && n <= 961) nPass++; else begin nFail++; $error("FAIL t2_cycles: %0d", n); end
        nChecks++; if (words.size() == 2) nPass++; else begin nFail++; $error("FAIL t2_nwords: %0d", words.size()); end
        nChecks++; if (((words.size() > 0) ? words[0] : 27'h0) === W_1280) nPass++; else begin nFail++; $error("FAIL t2_word0"); end
        nChecks++; if (((words.size() > 1) ? words[1] : 27'h0) === W_1101) nPass++; else begin nFail++; $error("FAIL t2_word1"); end
        nChecks++; if (romAddr === 2'd2) nPass++; else begin nFail++; $error("FAIL t2_romaddr: %0h", romAddr); end

        clearMon();
        pulseStart();
        repeat (200) step();
        rstN = 1'b0;
        step();
        nChecks++; if (scl === 1'b1) nPass++; else begin nFail++; $error("FAIL t3_scl: %0h", scl); end
        nChecks++; if (sda === 1'b1) nPass++; else begin nFail++; $error("FAIL t3_sda: %0h", sda); end
        nChecks++; if (busy === 1'b0) nPass++; else begin nFail++; $error("FAIL t3_busy: %0h", busy); end
        nChecks++; if (done === 1'b0) nPass++; else begin nFail++; $error("FAIL t3_done: %0h", done); end
        nChecks++; if (romAddr === 2'd0) nPass++; else begin nFail++; $error("FAIL t3_romaddr: %0h", romAddr); end
        rstN = 1'b1;
        rise0 = sclRises;
        repeat (300) step();
        nChecks++; if (sclRises == rise0) nPass++; else begin nFail++; $error("FAIL t3_quiet: %0d vs %0d", sclRises, rise0); end
        nChecks++; if (busy === 1'b0) nPass++; else begin nFail++; $error("FAIL t3_idle_busy: %0h", busy); end
        clearMon();
        pulseStart();
        n = 1;
        waitDone(3000, n);
        nChecks++; if (n >= 959 && n <= 961) nPass++; else begin nFail++; $error("FAIL t3_cycles: %0d", n); end
        nChecks++; if (words.size() == 2) nPass++; else begin nFail++; $error("FAIL t3_nwords: %0d", words.size()); end
        nChecks++; if (((words.size() > 0) ? words[0] : 27'h0) === W_1280) nPass++; else begin nFail++; $error("FAIL t3_word0"); end

        rom = '{16'h1280, 16'h1101, 16'h1A22, 16'h3344};
        clearMon();
        pulseStart();
        n = 1;
        waitDone(6000, n);
        nChecks++; if (n >= 1905 && n <= 1907) nPass++; else begin nFail++; $error("FAIL t4_cycles: %0d", n); end
        nChecks++; if (done === 1'b1) nPass++; else begin nFail++; $error("FAIL t4_done: %0h", done); end
        nChecks++; if (words.size() == 4) nPass++; else begin nFail++; $error("FAIL t4_nwords: %0d", words.size()); end
        nChecks++; if (((words.size() > 3) ? words[3] : 27'h0) === W_3344) nPass++; else begin nFail++; $error("FAIL t4_word3"); end
        nChecks++; if (romAddr === 2'd0) nPass++; else begin nFail++; $error("FAIL t4_romaddr: %0h", romAddr); end

        rom = '{16'hFFFF, 16'h1280, 16'h1101, 16'h3344};
        clearMon();
        rise0 = sclRises;
        pulseStart();
        n = 1;
        waitDone(100, n);
        nChecks++; if (n >= 12 && n <= 14) nPass++; else begin nFail++; $error("FAIL t5_cycles: %0d", n); end
        nChecks++; if (done === 1'b1) nPass++; else begin nFail++; $error("FAIL t5_done: %0h", done); end
        nChecks++; if (sclRises == rise0) nPass++; else begin nFail++; $error("FAIL t5_no_edges: %0d vs %0d", sclRises, rise0); end
        nChecks++; if (romAddr === 2'd0) nPass++; else begin nFail++; $error("FAIL t5_romaddr: %0h", romAddr); end
        nChecks++; if (badStable == 0) nPass++; else begin nFail++; $error("FAIL t5_sda_stable: %0d", badStable); end
        nChecks++; if (badWidth == 0) nPass++; else begin nFail++; $error("FAIL t5_scl_width: %0d", badWidth); end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
